// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial two's-complement adder/subtractor.
// An operation is captured on start, processed DIGIT bits per clock from the
// LSB upwards, and the full result is published on sum/cout/ovf together with
// a one-cycle done pulse. Results stay frozen until the next operation ends.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             done
);

  // Number of digit steps per operation and the counter width needed for it.
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;      // first operand, shifted right one digit per step
  logic [WIDTH-1:0] op_b;      // second operand (inverted for subtract), shifted likewise
  logic [WIDTH-1:0] acc;       // partial result, filled from the top down
  logic             carry;     // carry between digit steps
  logic [CNT_W-1:0] cnt;       // digit index of the step being executed

  logic [DIGIT:0]   slice;     // current digit sum including its carry out
  logic [WIDTH-1:0] acc_next;  // partial result after absorbing the current digit
  logic             last;      // current step handles the most significant digit
  logic             msb_cin;   // carry into the MSB, valid on the last step

  // Combinational digit adder and the next partial-result value.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    slice    = '0;
    acc_next = '0;
    last     = 1'b0;
    msb_cin  = 1'b0;

    slice    = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + (DIGIT+1)'(carry);
    // New digit enters at the top; after N steps the LSB digit sits at bit 0.
    acc_next = (acc >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    last     = (cnt == CNT_W'(N - 1));
    // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ cin.
    msb_cin  = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ slice[DIGIT-1];
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand, carry and counter registers are reset as well, so a
      // reset mid-operation leaves no trace of the abandoned operation.
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      ready <= 1'b1;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values of the others regardless of statement order.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && ready) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;            // +1 completes the two's complement of b
            cnt   <= '0;
            acc   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end

        RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          carry <= slice[DIGIT];
          acc   <= acc_next;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            sum   <= acc_next;
            cout  <= slice[DIGIT];
            ovf   <= msb_cin ^ slice[DIGIT];
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: five serial_addsub instances (8/1, 8/4, 4/1, 4/2, 4/4)
// compared every cycle against a timing/arithmetic reference model, plus
// directed operations with hand-computed results.
module tb_serial_addsub;

  localparam int NI = 5;
  localparam int W_OF [NI] = '{8, 8, 4, 4, 4};
  localparam int N_OF [NI] = '{8, 2, 4, 2, 1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NI-1:0] st, sb, rdy, dn, co, ov;
  logic [7:0]    in_a [NI];
  logic [7:0]    in_b [NI];
  logic [7:0]    sm   [NI];
  logic [7:0]    s0, s1;
  logic [3:0]    s2, s3, s4;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]),
    .a(in_a[0]), .b(in_b[0]), .ready(rdy[0]), .sum(s0), .cout(co[0]), .ovf(ov[0]), .done(dn[0]));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]),
    .a(in_a[1]), .b(in_b[1]), .ready(rdy[1]), .sum(s1), .cout(co[1]), .ovf(ov[1]), .done(dn[1]));
  serial_addsub #(.WIDTH(4), .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sb[2]),
    .a(in_a[2][3:0]), .b(in_b[2][3:0]), .ready(rdy[2]), .sum(s2), .cout(co[2]), .ovf(ov[2]), .done(dn[2]));
  serial_addsub #(.WIDTH(4), .DIGIT(2)) u3 (.clk(clk), .rst_n(rst_n), .start(st[3]), .sub(sb[3]),
    .a(in_a[3][3:0]), .b(in_b[3][3:0]), .ready(rdy[3]), .sum(s3), .cout(co[3]), .ovf(ov[3]), .done(dn[3]));
  serial_addsub #(.WIDTH(4), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .start(st[4]), .sub(sb[4]),
    .a(in_a[4][3:0]), .b(in_b[4][3:0]), .ready(rdy[4]), .sum(s4), .cout(co[4]), .ovf(ov[4]), .done(dn[4]));

  always_comb begin
    sm[0] = s0;
    sm[1] = s1;
    sm[2] = {4'b0, s2};
    sm[3] = {4'b0, s3};
    sm[4] = {4'b0, s4};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d] @%0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract with range tests.
  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
  } res_t;

  function automatic res_t ref_op(input int w, input int a, input int b, input bit sub);
    res_t r;
    int m, h, sa, sb2, ru, rs;
    m  = 1 << w;
    h  = m / 2;
    a  = a % m;
    b  = b % m;
    sa  = (a >= h) ? a - m : a;
    sb2 = (b >= h) ? b - m : b;
    ru  = sub ? a - b : a + b;
    rs  = sub ? sa - sb2 : sa + sb2;
    r.s = 8'(((ru % m) + m) % m);
    r.c = sub ? (a >= b) : (a + b >= m);
    r.v = (rs < -h) || (rs >= h);
    return r;
  endfunction

  // Timing model: an accepted op completes N edges later, then one done cycle,
  // then idle again; requests are only taken while idle.
  int   m_left [NI];
  bit   m_done [NI];
  bit   m_acc  [NI];
  res_t m_res  [NI];
  res_t m_pend [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_left[i] <= 0;
        m_done[i] <= 1'b0;
        m_acc[i]  <= 1'b0;
        m_res[i]  <= '0;
        m_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_acc[i] <= 1'b0;
        if (m_done[i]) begin
          m_done[i] <= 1'b0;
        end else if (m_left[i] > 0) begin
          if (m_left[i] == 1) begin
            m_res[i]  <= m_pend[i];
            m_done[i] <= 1'b1;
          end
          m_left[i] <= m_left[i] - 1;
        end else if (st[i]) begin
          m_pend[i] <= ref_op(W_OF[i], int'(in_a[i]), int'(in_b[i]), sb[i]);
          m_left[i] <= N_OF[i];
          m_acc[i]  <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check("ready", i, 32'(rdy[i]), 32'(m_left[i] == 0 && !m_done[i]));
      check("done",  i, 32'(dn[i]),  32'(m_done[i]));
      check("sum",   i, 32'(sm[i]),  32'(m_res[i].s));
      check("cout",  i, 32'(co[i]),  32'(m_res[i].c));
      check("ovf",   i, 32'(ov[i]),  32'(m_res[i].v));
    end
  end

  // Directed op; call right after a negedge with the instance idle.
  task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b, input bit sub,
                        input logic [7:0] es, input bit ec, input bit ev, input int elat, input string nm);
    int edges;
    st[idx] = 1'b1; in_a[idx] = a; in_b[idx] = b; sb[idx] = sub;
    @(posedge clk); #1;
    st[idx] = 1'b0;
    edges = 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (dn[idx]) break;
    end
    check({nm, "_lat"},  idx, 32'(edges),   32'(elat));
    check({nm, "_sum"},  idx, 32'(sm[idx]), 32'(es));
    check({nm, "_cout"}, idx, 32'(co[idx]), 32'(ec));
    check({nm, "_ovf"},  idx, 32'(ov[idx]), 32'(ev));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Exhaustive W=4 sweep with start held high.
  task automatic sweep(input int idx);
    int k, cyc, limit;
    logic [8:0] c;
    k = 0; cyc = 0;
    limit = 512 * (N_OF[idx] + 2) + 50;
    c = '0;
    in_a[idx] = {4'b0, c[3:0]}; in_b[idx] = {4'b0, c[7:4]}; sb[idx] = c[8];
    st[idx] = 1'b1;
    while (k < 512 && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      if (m_acc[idx]) begin
        k++;
        if (k < 512) begin
          c = 9'(k);
          in_a[idx] = {4'b0, c[3:0]}; in_b[idx] = {4'b0, c[7:4]}; sb[idx] = c[8];
        end else begin
          st[idx] = 1'b0;
        end
      end
    end
    st[idx] = 1'b0;
    check("sweep_accepts", idx, 32'(k), 32'd512);
  endtask

  // Random start/operand traffic, including requests while busy.
  task automatic rand_traffic(input int idx, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      st[idx]   = 1'($urandom_range(0, 1));
      sb[idx]   = 1'($urandom_range(0, 1));
      in_a[idx] = 8'($urandom);
      in_b[idx] = 8'($urandom);
    end
    @(negedge clk);
    st[idx] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [7:0] psum;
    rst_n = 1'b0;
    st = '0; sb = '0;
    for (int i = 0; i < NI; i++) begin in_a[i] = '0; in_b[i] = '0; end
    repeat (2) @(negedge clk);
    check("rst_ready", 0, 32'(rdy[0]), 32'd1);
    check("rst_sum",   0, 32'(sm[0]),  32'd0);
    check("rst_done",  0, 32'(dn[0]),  32'd0);
    rst_n = 1'b1;

    // Hand-computed results pin both the DUT and the model.
    run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, "ff_p_01");
    run_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8, "7f_p_01");
    run_op(0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 8, "05_m_07");
    run_op(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 2, "80_m_01");

    // Busy: a second request in RUN cycle 3 must be dropped.
    st[0] = 1'b1; in_a[0] = 8'h01; in_b[0] = 8'h02; sb[0] = 1'b0;
    @(posedge clk); #1; st[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1; st[0] = 1'b1; in_a[0] = 8'h10; in_b[0] = 8'h10;
    @(posedge clk); #1; st[0] = 1'b0;
    pulses = 0; psum = 8'hXX;
    for (int n = 0; n < 24; n++) begin
      @(posedge clk); #1;
      if (dn[0]) begin pulses++; psum = sm[0]; end
    end
    check("busy_pulses", 0, 32'(pulses), 32'd1);
    check("busy_sum",    0, 32'(psum),   32'h03);
    @(negedge clk);

    // Reset during RUN cycle 4 abandons the operation.
    st[0] = 1'b1; in_a[0] = 8'h11; in_b[0] = 8'h22; sb[0] = 1'b0;
    @(posedge clk); #1; st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    check("mrst_sum",   0, 32'(sm[0]),  32'd0);
    check("mrst_ready", 0, 32'(rdy[0]), 32'd1);
    check("mrst_done",  0, 32'(dn[0]),  32'd0);
    check("mrst_cout",  0, 32'(co[0]),  32'd0);
    check("mrst_ovf",   0, 32'(ov[0]),  32'd0);
    @(posedge clk); #1;
    check("mrst_nodone", 0, 32'(dn[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 8, "03_p_04");

    fork
      sweep(2);
      sweep(3);
      sweep(4);
      rand_traffic(0, 1500);
      rand_traffic(1, 1500);
    join
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
